lif_neuron_array: RTL and testbench

- Parametrised multi-channel leaky integrate-and-fire membrane block; next generation of the single-channel accumulator with fixed 0.75 leak.
- Holds NCH signed membrane potentials. Accepts weighted input events through a valid/ready handshake.
- On each timestep tick, runs a sequential sweep: leak, threshold, spike, reset-to-zero and refractory handling, one channel per cycle.
- Sits between the synapse/weight mux and the spike router.

---
 rtl/lif_neuron_array.sv | 177 +++++++++++++++++
 tb/tb_lif_neuron_array.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: NCH-channel leaky integrate-and-fire membranes with a one-channel-per-cycle tick sweep.
// Build option LIF_NEG_FLOOR_EN: clamp every membrane update at zero instead of allowing negative potentials.
`default_nettype none

module lif_neuron_array #(
    parameter int NCH     = 4,
    parameter int CH_W    = 2,
    parameter int W       = 8,
    parameter int LEAK_S1 = 1,
    parameter int LEAK_S2 = 2,
    parameter int THRESH  = 64,
    parameter int REFRAC  = 2,
    parameter int RF_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [W-1:0]        in_w,
    input  logic                tick,
    output logic                busy,
    output logic                done,
    output logic [NCH-1:0]      spk_vec,
    output logic                overrun,
    input  logic [CH_W-1:0]     rd_ch,
    output logic [W-1:0]        rd_v
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    localparam logic signed [W-1:0] C_THRESH = W'(THRESH);
    localparam logic [RF_W-1:0]     C_REFRAC = RF_W'(REFRAC);
    localparam logic [CH_W-1:0]     C_LAST   = CH_W'(NCH - 1);

    state_t                 state_q, state_d;
    logic [CH_W-1:0]        idx_q, idx_d;
    logic signed [W-1:0]    v_q    [NCH];
    logic signed [W-1:0]    v_d    [NCH];
    logic [RF_W-1:0]        refr_q [NCH];
    logic [RF_W-1:0]        refr_d [NCH];
    logic [NCH-1:0]         spk_sh_q, spk_sh_d;
    logic [NCH-1:0]         spk_vec_q, spk_vec_d;
    logic                   done_q, done_d;
    logic                   overrun_q, overrun_d;

    function automatic logic signed [W-1:0] floor_neg(input logic signed [W-1:0] x);
`ifdef LIF_NEG_FLOOR_EN
        return x[W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Sum carried in W+1 bits; disagreement of the top two bits means overflow.
    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic signed [W:0]   s;
        logic signed [W-1:0] r;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1]) begin
            r = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            r = s[W-1:0];
        end
        return floor_neg(r);
    endfunction

    function automatic logic signed [W-1:0] leak(input logic signed [W-1:0] v);
        logic signed [W-1:0] l;
        l = (v >>> LEAK_S1) + (v >>> LEAK_S2);
        return floor_neg(l);
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        v_d       = v_q;
        refr_d    = refr_q;
        spk_sh_d  = spk_sh_q;
        spk_vec_d = spk_vec_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            S_IDLE: begin
                // Out-of-range channels match no entry, so their events are simply dropped.
                if (in_valid) begin
                    for (int i = 0; i < NCH; i++) begin
                        if (in_ch == CH_W'(i) && refr_q[i] == '0) begin
                            v_d[i] = sat_add(v_q[i], in_w);
                        end
                    end
                end
                if (tick) begin
                    state_d = S_SWEEP;
                    idx_d   = '0;
                end
            end
            S_SWEEP: begin
                if (tick) begin
                    overrun_d = 1'b1;
                end
                for (int i = 0; i < NCH; i++) begin
                    if (idx_q == CH_W'(i)) begin
                        if (refr_q[i] != '0) begin
                            refr_d[i]   = refr_q[i] - RF_W'(1);
                            v_d[i]      = '0;
                            spk_sh_d[i] = 1'b0;
                        end else if (v_q[i] >= C_THRESH) begin
                            refr_d[i]   = C_REFRAC;
                            v_d[i]      = '0;
                            spk_sh_d[i] = 1'b1;
                        end else begin
                            v_d[i]      = leak(v_q[i]);
                            spk_sh_d[i] = 1'b0;
                        end
                    end
                end
                if (idx_q == C_LAST) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    spk_vec_d = spk_sh_d;
                end else begin
                    idx_d = idx_q + CH_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            spk_sh_q  <= '0;
            spk_vec_q <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                v_q[i]    <= '0;
                refr_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            spk_sh_q  <= spk_sh_d;
            spk_vec_q <= spk_vec_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < NCH; i++) begin
                v_q[i]    <= v_d[i];
                refr_q[i] <= refr_d[i];
            end
        end
    end

    always_comb begin
        rd_v = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_v = v_q[i];
            end
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q == S_SWEEP);
    assign done     = done_q;
    assign spk_vec  = spk_vec_q;
    assign overrun  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array: sweep results are queued at tick issue and checked by a done monitor.
`default_nettype none

module tb_lif_neuron_array;

`ifdef LIF_NEG_FLOOR_EN
    localparam bit FLOOR = 1'b1;
`else
    localparam bit FLOOR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_ch = '0;
    logic [7:0] in_w = '0;
    logic       tick = 1'b0;
    logic       busy, done, overrun;
    logic [3:0] spk_vec;
    logic [1:0] rd_ch = '0;
    logic [7:0] rd_v;

    lif_neuron_array dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_w(in_w), .tick(tick), .busy(busy), .done(done),
        .spk_vec(spk_vec), .overrun(overrun), .rd_ch(rd_ch), .rd_v(rd_v)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] spk;
        int         t_acc;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest queued sweep.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("spk_vec", int'(spk_vec), int'(e.spk));
                check("done_latency", cyc - e.t_acc, 4);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_v(input int ch, input int expv);
        rd_ch = ch[1:0];
        #1;
        check($sformatf("rd_v_ch%0d", ch), int'($signed(rd_v)), expv);
    endtask

    task automatic send(input int ch, input int w);
        logic rdy;
        bit   ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_ch    = ch[1:0];
        in_w     = w[7:0];
        for (int k = 0; k < 50; k++) begin
            rdy = in_ready;
            step();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("sweep_timeout", 0, 1);
    endtask

    task automatic do_tick(input logic [3:0] spk, input bit with_ev, input int ch, input int w);
        exp_t e;
        tick     = 1'b1;
        in_valid = with_ev;
        in_ch    = ch[1:0];
        in_w     = w[7:0];
        step();
        tick     = 1'b0;
        in_valid = 1'b0;
        e.spk    = spk;
        e.t_acc  = cyc;
        exp_q.push_back(e);
        wait_idle();
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) chk_v(c, 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_spk_vec", int'(spk_vec), 0);
        check("rst_overrun", int'(overrun), 0);

        // Accumulate to 80 and fire channel 1.
        send(1, 40);
        send(1, 40);
        chk_v(1, 80);
        do_tick(4'b0010, 1'b0, 0, 0);
        chk_v(1, 0);

        // Refractory channel drops events.
        send(1, 50);
        chk_v(1, 0);

        // Leak in both signs across two ticks (also drains ch1 refractory).
        send(0, 40);
        send(2, -40);
        do_tick(4'b0000, 1'b0, 0, 0);
        chk_v(0, 30);
        chk_v(2, FLOOR ? 0 : -30);
        do_tick(4'b0000, 1'b0, 0, 0);
        chk_v(0, 22);
        chk_v(2, FLOOR ? 0 : -23);

        send(1, 70);
        chk_v(1, 70);
        do_tick(4'b0010, 1'b0, 0, 0);
        chk_v(0, 16);
        chk_v(2, FLOOR ? 0 : -18);

        // Saturation in both directions.
        send(3, 100);
        send(3, 100);
        chk_v(3, 127);
        send(3, -100);
        chk_v(3, 27);
        send(3, -100);
        send(3, -100);
        chk_v(3, FLOOR ? 0 : -128);

        // Event held off during a sweep, plus an overrunning tick at sweep cycle 2.
        begin
            exp_t e;
            tick = 1'b1;
            step();
            tick    = 1'b0;
            e.spk   = 4'b0000;
            e.t_acc = cyc;
            exp_q.push_back(e);
            in_valid = 1'b1;
            in_ch    = 2'd0;
            in_w     = 8'd5;
            for (int k = 0; k < 4; k++) begin
                check($sformatf("held_in_ready_%0d", k), int'(in_ready), 0);
                tick = (k == 1);
                step();
            end
            tick = 1'b0;
            check("ready_after_sweep", int'(in_ready), 1);
            check("overrun_set", int'(overrun), 1);
            step();
            in_valid = 1'b0;
            chk_v(0, 17);
            repeat (6) step();
            check("no_second_sweep", int'(busy), 0);
            chk_v(2, FLOOR ? 0 : -14);
            chk_v(3, FLOOR ? 0 : -96);
        end

        // Tick and event in the same cycle: sweep sees 17+64.
        do_tick(4'b0001, 1'b1, 0, 64);
        chk_v(0, 0);
        chk_v(2, FLOOR ? 0 : -11);
        chk_v(3, FLOOR ? 0 : -72);

        // Back-to-back tick issued in the done cycle.
        check("done_at_b2b", int'(done), 1);
        do_tick(4'b0000, 1'b0, 0, 0);
        chk_v(2, FLOOR ? 0 : -9);
        chk_v(3, FLOOR ? 0 : -54);

        send(1, 70);
        do_tick(4'b0010, 1'b0, 0, 0);
        check("spk_before_abort", int'(spk_vec), 2);

        // Reset in the middle of a sweep.
        send(0, 30);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) chk_v(c, 0);
        check("abort_spk_vec", int'(spk_vec), 0);
        check("abort_overrun", int'(overrun), 0);
        check("abort_busy", int'(busy), 0);
        repeat (8) step();
        check("abort_no_done_busy", int'(busy), 0);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
